// File: rtl/valid_dirty_array.sv
// -----------------------------------------------------------------------------
// valid_dirty_array
// Per-line state store for an N-way set-associative cache: one valid bit and
// one dirty bit per (set, way). Sits beside the tag RAM; read by the hit/miss
// logic, written by the controller FSM.
//
// Features:
//   - per-way masked writes (accepted only while the sweep FSM is idle)
//   - registered read of all ways of one set (1-cycle latency)
//   - invalidate-all sweep that hands every valid+dirty set to the
//     write-back engine (valid/ready report) before clearing it
//
// Parameters:
//   SETS      number of sets (index range 0..SETS-1)
//   INDEX_W   index width, SETS <= 2**INDEX_W
//   WAYS      associativity, width of all per-way vectors
//   WRITEBACK 1 = dirty bits stored and reported, 0 = dirty bits forced 0
//
// Ports:
//   clk          in   single clock, all state changes on posedge
//   rst_n        in   asynchronous active-low reset
//   rd_en        in   read strobe
//   rd_index     in   set to read
//   rd_valid     out  valid bits of rd_index (registered)
//   rd_dirty     out  dirty bits of rd_index (registered)
//   wr_en        in   write strobe
//   wr_index     in   set to write
//   wr_way_mask  in   ways to update
//   wr_valid     in   valid value written to masked ways
//   wr_dirty     in   dirty value written to masked ways
//   inv_all_req  in   start invalidate-all sweep (sampled in IDLE only)
//   inv_busy     out  sweep in progress
//   inv_done     out  one-cycle pulse at sweep end
//   dirty_vld    out  dirty-set report valid
//   dirty_index  out  set being reported
//   dirty_ways   out  ways of that set that are valid and dirty
//   dirty_rdy    in   write-back engine accepts report
// -----------------------------------------------------------------------------
module valid_dirty_array #(
    parameter int SETS      = 64,
    parameter int INDEX_W   = 6,
    parameter int WAYS      = 4,
    parameter int WRITEBACK = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [WAYS-1:0]    rd_valid,
    output logic [WAYS-1:0]    rd_dirty,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [WAYS-1:0]    wr_way_mask,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic               inv_all_req,
    output logic               inv_busy,
    output logic               inv_done,
    output logic               dirty_vld,
    output logic [INDEX_W-1:0] dirty_index,
    output logic [WAYS-1:0]    dirty_ways,
    input  logic               dirty_rdy
);

    // Sweep FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [INDEX_W:0]   SETS_L   = (INDEX_W+1)'(SETS);
    localparam logic [INDEX_W-1:0] LAST_PTR = INDEX_W'(SETS - 1);
    // With write-back disabled every dirty bit is tied low at its source, so
    // the sweep never finds anything to report.
    localparam logic               WB_EN    = (WRITEBACK != 0);

    // Storage and registered state
    logic [WAYS-1:0]    valid_r [SETS];
    logic [WAYS-1:0]    dirty_r [SETS];
    logic [1:0]         state_r;
    logic [INDEX_W-1:0] ptr_r;
    logic [WAYS-1:0]    rd_valid_r;
    logic [WAYS-1:0]    rd_dirty_r;
    logic               inv_busy_r;
    logic               inv_done_r;
    logic               dirty_vld_r;
    logic [INDEX_W-1:0] dirty_index_r;
    logic [WAYS-1:0]    dirty_ways_r;

    // Combinational helpers
    logic               rd_in_range_s;
    logic               wr_in_range_s;
    logic               wr_ok_s;
    logic [WAYS-1:0]    rd_row_valid_s;
    logic [WAYS-1:0]    rd_row_dirty_s;
    logic [WAYS-1:0]    wr_row_valid_s;
    logic [WAYS-1:0]    wr_row_dirty_s;
    logic [WAYS-1:0]    scan_dirty_s;
    logic [1:0]         state_nxt_s;
    logic [INDEX_W-1:0] ptr_nxt_s;
    logic               clr_en_s;
    logic               rpt_start_s;
    logic               rpt_accept_s;

    assign rd_in_range_s = ({1'b0, rd_index} < SETS_L);
    assign wr_in_range_s = ({1'b0, wr_index} < SETS_L);
    // Writes only land while no sweep is running, so a sweep always finishes
    // with every set invalid.
    assign wr_ok_s       = wr_en && (state_r == ST_IDLE) && wr_in_range_s;
    assign rpt_accept_s  = (state_r == ST_REPORT) && dirty_rdy;

    // Read-side row fetch; out-of-range sets read as zero
    always_comb begin
        rd_row_valid_s = '0;
        rd_row_dirty_s = '0;
        if (rd_in_range_s) begin
            rd_row_valid_s = valid_r[rd_index];
            rd_row_dirty_s = dirty_r[rd_index];
        end else begin
            rd_row_valid_s = '0;
            rd_row_dirty_s = '0;
        end
    end

    // Merge masked write data into the addressed row; dirty requires valid
    always_comb begin
        wr_row_valid_s = '0;
        wr_row_dirty_s = '0;
        if (wr_in_range_s) begin
            wr_row_valid_s = (valid_r[wr_index] & ~wr_way_mask)
                           | (wr_way_mask & {WAYS{wr_valid}});
            wr_row_dirty_s = (dirty_r[wr_index] & ~wr_way_mask)
                           | (wr_way_mask & {WAYS{wr_valid & wr_dirty & WB_EN}});
        end else begin
            wr_row_valid_s = '0;
            wr_row_dirty_s = '0;
        end
    end

    // Lines of the swept set that must be written back before clearing
    always_comb begin
        scan_dirty_s = '0;
        if (WB_EN) begin
            scan_dirty_s = valid_r[ptr_r] & dirty_r[ptr_r];
        end else begin
            scan_dirty_s = '0;
        end
    end

    // Sweep FSM next-state and per-set clear decision
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        clr_en_s    = 1'b0;
        rpt_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (inv_all_req) begin
                    state_nxt_s = ST_SCAN;
                    ptr_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_dirty_s != '0) begin
                    state_nxt_s = ST_REPORT;
                    rpt_start_s = 1'b1;
                end else begin
                    clr_en_s = 1'b1;
                    if (ptr_r == LAST_PTR) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        ptr_nxt_s = ptr_r + INDEX_W'(1);
                    end
                end
            end
            ST_REPORT: begin
                // The set is cleared only once the write-back engine has taken
                // the report; until then everything stays frozen.
                if (dirty_rdy) begin
                    clr_en_s = 1'b1;
                    if (ptr_r == LAST_PTR) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SCAN;
                        ptr_nxt_s   = ptr_r + INDEX_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = '0;
            end
        endcase
    end

    // Valid/dirty storage: masked writes in IDLE, per-set clears during sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
            end
        end else begin
            if (wr_ok_s) begin
                valid_r[wr_index] <= wr_row_valid_s;
                dirty_r[wr_index] <= wr_row_dirty_s;
            end
            if (clr_en_s) begin
                valid_r[ptr_r] <= '0;
                dirty_r[ptr_r] <= '0;
            end
        end
    end

    // Registered read port; rd_en low holds the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= '0;
            rd_dirty_r <= '0;
        end else if (rd_en) begin
            rd_valid_r <= rd_row_valid_s;
            rd_dirty_r <= rd_row_dirty_s;
        end
    end

    // Sweep FSM state, pointer and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            inv_busy_r <= 1'b0;
            inv_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            inv_busy_r <= (state_nxt_s != ST_IDLE);
            inv_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Dirty-set report handshake; payload holds stable while dirty_vld is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_vld_r   <= 1'b0;
            dirty_index_r <= '0;
            dirty_ways_r  <= '0;
        end else if (rpt_start_s) begin
            dirty_vld_r   <= 1'b1;
            dirty_index_r <= ptr_r;
            dirty_ways_r  <= scan_dirty_s;
        end else if (rpt_accept_s) begin
            dirty_vld_r   <= 1'b0;
        end
    end

    assign rd_valid    = rd_valid_r;
    assign rd_dirty    = rd_dirty_r;
    assign inv_busy    = inv_busy_r;
    assign inv_done    = inv_done_r;
    assign dirty_vld   = dirty_vld_r;
    assign dirty_index = dirty_index_r;
    assign dirty_ways  = dirty_ways_r;

endmodule

// File: tb/tb_valid_dirty_array.sv
// -----------------------------------------------------------------------------
// tb_valid_dirty_array
// Directed self-checking bench for valid_dirty_array. One instance with
// write-back enabled, one with it disabled; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_valid_dirty_array;

    logic       clk;
    logic       rst_n;
    logic       rd_en, wr_en, wr_valid, wr_dirty, inv_all_req, dirty_rdy;
    logic [5:0] rd_index, wr_index, dirty_index;
    logic [3:0] wr_way_mask, rd_valid, rd_dirty, dirty_ways;
    logic       inv_busy, inv_done, dirty_vld;

    logic       b_rd_en, b_wr_en, b_wr_valid, b_wr_dirty, b_inv_all_req, b_dirty_rdy;
    logic [5:0] b_rd_index, b_wr_index, b_dirty_index;
    logic [3:0] b_wr_way_mask, b_rd_valid, b_rd_dirty, b_dirty_ways;
    logic       b_inv_busy, b_inv_done, b_dirty_vld;

    int checks;
    int failures;
    int cyc;
    logic seen;

    valid_dirty_array #(.SETS(64), .INDEX_W(6), .WAYS(4), .WRITEBACK(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
        .wr_en(wr_en), .wr_index(wr_index), .wr_way_mask(wr_way_mask),
        .wr_valid(wr_valid), .wr_dirty(wr_dirty),
        .inv_all_req(inv_all_req), .inv_busy(inv_busy), .inv_done(inv_done),
        .dirty_vld(dirty_vld), .dirty_index(dirty_index), .dirty_ways(dirty_ways),
        .dirty_rdy(dirty_rdy)
    );

    valid_dirty_array #(.SETS(64), .INDEX_W(6), .WAYS(4), .WRITEBACK(0)) u_dut_nowb (
        .clk(clk), .rst_n(rst_n),
        .rd_en(b_rd_en), .rd_index(b_rd_index), .rd_valid(b_rd_valid), .rd_dirty(b_rd_dirty),
        .wr_en(b_wr_en), .wr_index(b_wr_index), .wr_way_mask(b_wr_way_mask),
        .wr_valid(b_wr_valid), .wr_dirty(b_wr_dirty),
        .inv_all_req(b_inv_all_req), .inv_busy(b_inv_busy), .inv_done(b_inv_done),
        .dirty_vld(b_dirty_vld), .dirty_index(b_dirty_index), .dirty_ways(b_dirty_ways),
        .dirty_rdy(b_dirty_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr_a(input logic [5:0] idx, input logic [3:0] mask, input logic v, input logic d);
        wr_en = 1'b1; wr_index = idx; wr_way_mask = mask; wr_valid = v; wr_dirty = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_a(input logic [5:0] idx);
        rd_en = 1'b1; rd_index = idx;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr_b(input logic [5:0] idx, input logic [3:0] mask, input logic v, input logic d);
        b_wr_en = 1'b1; b_wr_index = idx; b_wr_way_mask = mask; b_wr_valid = v; b_wr_dirty = d;
        tick();
        b_wr_en = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; seen = 1'b0;
        rst_n = 1'b0;
        rd_en = 1'b0; rd_index = 6'd0; wr_en = 1'b0; wr_index = 6'd0; wr_way_mask = 4'd0;
        wr_valid = 1'b0; wr_dirty = 1'b0; inv_all_req = 1'b0; dirty_rdy = 1'b0;
        b_rd_en = 1'b0; b_rd_index = 6'd0; b_wr_en = 1'b0; b_wr_index = 6'd0; b_wr_way_mask = 4'd0;
        b_wr_valid = 1'b0; b_wr_dirty = 1'b0; b_inv_all_req = 1'b0; b_dirty_rdy = 1'b0;

        // Reset state
        #12;
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_dirty", 32'(rd_dirty), 32'h0);
        check("rst_inv_busy", 32'(inv_busy), 32'h0);
        check("rst_inv_done", 32'(inv_done), 32'h0);
        check("rst_dirty_vld", 32'(dirty_vld), 32'h0);
        check("rst_dirty_index", 32'(dirty_index), 32'h0);
        check("rst_dirty_ways", 32'(dirty_ways), 32'h0);
        rst_n = 1'b1;
        tick();

        // Masked write, then a partial overwrite of one way
        wr_a(6'd3, 4'b0101, 1'b1, 1'b1);
        rd_a(6'd3);
        check("mask_valid", 32'(rd_valid), 32'h5);
        check("mask_dirty", 32'(rd_dirty), 32'h5);
        wr_a(6'd3, 4'b0100, 1'b1, 1'b0);
        rd_a(6'd3);
        check("partial_valid", 32'(rd_valid), 32'h5);
        check("partial_dirty", 32'(rd_dirty), 32'h1);
        wr_a(6'd3, 4'b0000, 1'b0, 1'b0);
        rd_a(6'd3);
        check("nomask_valid", 32'(rd_valid), 32'h5);

        // Dirty gated by valid
        wr_a(6'd4, 4'b1100, 1'b1, 1'b1);
        wr_a(6'd4, 4'b0100, 1'b0, 1'b1);
        rd_a(6'd4);
        check("gate_valid", 32'(rd_valid), 32'h8);
        check("gate_dirty", 32'(rd_dirty), 32'h8);

        // rd_en low holds the previous result
        rd_a(6'd3);
        rd_index = 6'd4;
        tick();
        check("hold_valid", 32'(rd_valid), 32'h5);
        check("hold_dirty", 32'(rd_dirty), 32'h1);

        // Same-edge read and write of set 7
        wr_en = 1'b1; wr_index = 6'd7; wr_way_mask = 4'hF; wr_valid = 1'b1; wr_dirty = 1'b0;
        rd_en = 1'b1; rd_index = 6'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("same_edge_old", 32'(rd_valid), 32'h0);
        rd_a(6'd7);
        check("same_edge_new", 32'(rd_valid), 32'hF);

        // Asynchronous reset between edges
        wr_a(6'd5, 4'hF, 1'b1, 1'b0);
        rd_a(6'd5);
        check("pre_rst_valid", 32'(rd_valid), 32'hF);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rd_valid), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        rd_a(6'd5);
        check("post_rst_set5", 32'(rd_valid), 32'h0);
        rd_a(6'd3);
        check("post_rst_set3", 32'(rd_valid), 32'h0);

        // Clean sweep: busy cycles 1..65, done only at 65; writes/requests ignored
        wr_a(6'd10, 4'hF, 1'b1, 1'b0);
        wr_a(6'd63, 4'h1, 1'b1, 1'b0);
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 70; c++) begin
            check($sformatf("clean_busy_c%0d", c), 32'(inv_busy), (c <= 65) ? 32'h1 : 32'h0);
            check($sformatf("clean_done_c%0d", c), 32'(inv_done), (c == 65) ? 32'h1 : 32'h0);
            if (c == 30) begin
                wr_en = 1'b1; wr_index = 6'd2; wr_way_mask = 4'hF; wr_valid = 1'b1; wr_dirty = 1'b1;
            end else if (c == 40) begin
                wr_en = 1'b0; inv_all_req = 1'b1;
            end else begin
                wr_en = 1'b0; inv_all_req = 1'b0;
            end
            tick();
        end
        rd_a(6'd10);
        check("clean_set10", 32'(rd_valid), 32'h0);
        rd_a(6'd63);
        check("clean_set63", 32'(rd_valid), 32'h0);
        rd_a(6'd2);
        check("ignored_wr_set2", 32'(rd_valid), 32'h0);

        // Dirty report with a stalled write-back engine
        wr_a(6'd2, 4'b0011, 1'b1, 1'b1);
        wr_a(6'd63, 4'b1000, 1'b1, 1'b1);
        wr_a(6'd20, 4'b0100, 1'b1, 1'b0);
        dirty_rdy = 1'b0;
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        cyc = 1;
        check("rep_c1_vld", 32'(dirty_vld), 32'h0);
        tick();
        check("rep_c2_vld", 32'(dirty_vld), 32'h0);
        tick();
        check("rep_c3_vld", 32'(dirty_vld), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rep2_vld_%0d", k), 32'(dirty_vld), 32'h1);
            check($sformatf("rep2_idx_%0d", k), 32'(dirty_index), 32'd2);
            check($sformatf("rep2_ways_%0d", k), 32'(dirty_ways), 32'h3);
        end
        dirty_rdy = 1'b1;
        tick();
        dirty_rdy = 1'b0;
        check("rep2_acc_vld", 32'(dirty_vld), 32'h0);
        check("rep2_acc_busy", 32'(inv_busy), 32'h1);
        seen = 1'b0;
        while (!dirty_vld && cyc < 200) begin
            tick();
            if (inv_done) seen = 1'b1;
        end
        check("rep63_cycle", 32'(cyc), 32'd68);
        check("rep63_early_done", 32'(seen), 32'h0);
        check("rep63_idx", 32'(dirty_index), 32'd63);
        check("rep63_ways", 32'(dirty_ways), 32'h8);
        dirty_rdy = 1'b1;
        tick();
        dirty_rdy = 1'b0;
        check("rep_done", 32'(inv_done), 32'h1);
        check("rep_done_vld", 32'(dirty_vld), 32'h0);
        check("rep_done_busy", 32'(inv_busy), 32'h1);
        tick();
        check("rep_after_busy", 32'(inv_busy), 32'h0);
        check("rep_after_done", 32'(inv_done), 32'h0);
        rd_a(6'd20);
        check("rep_set20", 32'(rd_valid), 32'h0);
        rd_a(6'd2);
        check("rep_set2", 32'(rd_valid), 32'h0);

        // Reset in the middle of a report aborts without inv_done
        wr_a(6'd9, 4'b0001, 1'b1, 1'b1);
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        cyc = 1;
        while (!dirty_vld && cyc < 50) tick();
        check("abort_rep_idx", 32'(dirty_index), 32'd9);
        check("abort_rep_vld", 32'(dirty_vld), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_vld", 32'(dirty_vld), 32'h0);
        check("abort_busy", 32'(inv_busy), 32'h0);
        check("abort_idx", 32'(dirty_index), 32'h0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (inv_done || inv_busy) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'h0);
        rd_a(6'd9);
        check("abort_set9", 32'(rd_valid), 32'h0);

        // Write-back disabled build
        wr_b(6'd1, 4'hF, 1'b1, 1'b1);
        b_rd_en = 1'b1; b_rd_index = 6'd1;
        tick();
        b_rd_en = 1'b0;
        check("nowb_valid", 32'(b_rd_valid), 32'hF);
        check("nowb_dirty", 32'(b_rd_dirty), 32'h0);
        b_inv_all_req = 1'b1;
        tick();
        b_inv_all_req = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (!b_inv_done && cyc < 100) begin
            if (b_dirty_vld) seen = 1'b1;
            tick();
        end
        check("nowb_done_cycle", 32'(cyc), 32'd65);
        check("nowb_no_report", 32'(seen), 32'h0);
        b_rd_en = 1'b1; b_rd_index = 6'd1;
        tick();
        b_rd_en = 1'b0;
        check("nowb_swept", 32'(b_rd_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
